// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_op_sequencer
// Description : Issues CLR/LOAD/INC/DEC/SHR/SHL/ROR/ROL control strobes to an
//               external register. Rotate support needs REG_SEQ_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_op_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    input  logic                  cmd_fill,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  reg_msb,
    input  logic                  reg_lsb,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic                  ir,
    output logic                  il,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] c_OP_CLR  = 3'b000;
    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_INC  = 3'b010;
    localparam logic [2:0] c_OP_DEC  = 3'b011;
    localparam logic [2:0] c_OP_SHR  = 3'b100;
    localparam logic [2:0] c_OP_SHL  = 3'b101;
    localparam logic [2:0] c_OP_ROR  = 3'b110;
    localparam logic [2:0] c_OP_ROL  = 3'b111;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

`ifdef REG_SEQ_ROTATE_EN
    localparam logic c_ROT_EN = 1'b1;
`else
    localparam logic c_ROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_fill;
    logic                  r_cl;
    logic                  r_ld;
    logic                  r_inc;
    logic                  r_dec;
    logic                  r_sr;
    logic                  r_sl;
    logic                  r_done;
    logic                  r_err;
`ifdef REG_SEQ_ROTATE_EN
    logic                  r_rot;
`endif

    logic                  w_unit_op;
    logic                  w_rot_op;
    logic                  w_reject;
    logic                  w_skip;
    logic [CNT_WIDTH-1:0]  w_len;
    logic                  w_cl;
    logic                  w_ld;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_sr;
    logic                  w_sl;

    // Opcode decode for the command currently offered on the input.
    always_comb begin
        w_unit_op = (cmd_op == c_OP_CLR) || (cmd_op == c_OP_LOAD);
        w_rot_op  = (cmd_op == c_OP_ROR) || (cmd_op == c_OP_ROL);
        w_reject  = w_rot_op && !c_ROT_EN;
        w_len     = w_unit_op ? c_CNT_ONE : cmd_cnt;
        w_skip    = w_reject || (w_len == c_CNT_ZERO);
        w_cl      = (cmd_op == c_OP_CLR);
        w_ld      = (cmd_op == c_OP_LOAD);
        w_inc     = (cmd_op == c_OP_INC);
        w_dec     = (cmd_op == c_OP_DEC);
        w_sr      = (cmd_op == c_OP_SHR) || ((cmd_op == c_OP_ROR) && c_ROT_EN);
        w_sl      = (cmd_op == c_OP_SHL) || ((cmd_op == c_OP_ROL) && c_ROT_EN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_fill  <= 1'b0;
            r_cl    <= 1'b0;
            r_ld    <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_sr    <= 1'b0;
            r_sl    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef REG_SEQ_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (cmd_valid) begin
                        r_data <= cmd_data;
                        r_fill <= cmd_fill;
`ifdef REG_SEQ_ROTATE_EN
                        r_rot  <= w_rot_op;
`endif
                        if (w_skip) begin
                            // Zero-length or rejected commands finish without any strobe.
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= w_reject;
                        end else begin
                            r_state <= S_RUN;
                            r_cnt   <= w_len;
                            r_cl    <= w_cl;
                            r_ld    <= w_ld;
                            r_inc   <= w_inc;
                            r_dec   <= w_dec;
                            r_sr    <= w_sr;
                            r_sl    <= w_sl;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_cl    <= 1'b0;
                        r_ld    <= 1'b0;
                        r_inc   <= 1'b0;
                        r_dec   <= 1'b0;
                        r_sr    <= 1'b0;
                        r_sl    <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Serial inputs are only meaningful while a shift/rotate strobe is active.
`ifdef REG_SEQ_ROTATE_EN
    assign ir = r_sr & (r_rot ? reg_lsb : r_fill);
    assign il = r_sl & (r_rot ? reg_msb : r_fill);
`else
    logic w_unused;
    assign w_unused = reg_msb ^ reg_lsb;
    assign ir = r_sr & r_fill;
    assign il = r_sl & r_fill;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign data_out  = r_data;
    assign cl        = r_cl;
    assign ld        = r_ld;
    assign inc       = r_inc;
    assign dec       = r_dec;
    assign sr        = r_sr;
    assign sl        = r_sl;

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_op_sequencer
// Description : Scoreboard bench for reg_op_sequencer driving a modelled
//               downstream register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_op_sequencer;

    localparam int DW = 16;
    localparam int CW = 4;
`ifdef REG_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          cmd_fill = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic          reg_msb, reg_lsb;
    logic          cl, ld, inc, dec, sr, sl, ir, il;
    logic [DW-1:0] data_out;
    logic          busy, done, err;

    logic [DW-1:0] tb_reg = '0;
    logic [DW-1:0] reg_next = '0;
    logic [DW-1:0] model_reg = '0;
    int            total = 0;
    int            bad = 0;
    int            ncyc = 0;
    int            strobe_seen = 0;

    typedef struct {
        logic [2:0]    op;
        logic          fill;
        logic [DW-1:0] data;
        logic          err;
        int            n;
        logic [DW-1:0] regv;
        int            done_at;
    } exp_t;
    exp_t sb[$];

    assign reg_msb = tb_reg[DW-1];
    assign reg_lsb = tb_reg[0];

    reg_op_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
        .reg_msb(reg_msb), .reg_lsb(reg_lsb),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl), .ir(ir), .il(il),
        .data_out(data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_reg <= reg_next;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register effect of a whole command, computed arithmetically.
    function automatic void model(input logic [2:0] op, input int n, input logic fill,
                                  input logic [DW-1:0] data, inout logic [DW-1:0] r,
                                  output logic e, output int strobes, output int lat);
        logic [31:0] v;
        logic [31:0] ones;
        v = 32'(r);
        ones = (32'd1 << n) - 32'd1;
        e = 1'b0;
        strobes = n;
        lat = n + 1;
        case (op)
            3'd0: begin r = '0; strobes = 1; lat = 2; end
            3'd1: begin r = data; strobes = 1; lat = 2; end
            3'd2: r = DW'(v + 32'(n));
            3'd3: r = DW'(v - 32'(n));
            3'd4: r = DW'((v >> n) | (fill ? (ones << (DW - n)) : 32'd0));
            3'd5: r = DW'((v << n) | (fill ? ones : 32'd0));
            default: begin
                if (!ROT) begin
                    e = 1'b1; strobes = 0; lat = 1;
                end else if (op == 3'd6) begin
                    r = DW'((v >> n) | (v << (DW - n)));
                end else begin
                    r = DW'((v << n) | (v >> (DW - n)));
                end
            end
        endcase
    endfunction

    function automatic logic [5:0] stb_of(input logic [2:0] op);
        case (op)
            3'd0:      return 6'b100000;
            3'd1:      return 6'b010000;
            3'd2:      return 6'b001000;
            3'd3:      return 6'b000100;
            3'd4, 3'd6: return 6'b000010;
            default:   return 6'b000001;
        endcase
    endfunction

    // Monitor: per-cycle protocol checks and scoreboard pop on done.
    initial begin
        logic [5:0]    stb;
        logic          eir, eil;
        logic [DW-1:0] nx;
        exp_t          cur;
        forever begin
            @(negedge clk);
            ncyc++;
            reg_next = tb_reg;
            if (!rst_n) begin
                strobe_seen = 0;
                continue;
            end
            stb = {cl, ld, inc, dec, sr, sl};
            check("strobe_onehot0", 32'($onehot0(stb)), 1);
            check("ready_vs_busy", cmd_ready, !busy);
            check("busy", busy, sb.size() != 0);
            eir = 1'b0;
            eil = 1'b0;
            if (sb.size() != 0) begin
                cur = sb[0];
                if (stb != 6'b0) check("strobe_kind", stb, stb_of(cur.op));
                if (sr && cur.op == 3'd4) eir = cur.fill;
                if (sr && cur.op == 3'd6) eir = tb_reg[0];
                if (sl && cur.op == 3'd5) eil = cur.fill;
                if (sl && cur.op == 3'd7) eil = tb_reg[DW-1];
            end
            check("ir", ir, eir);
            check("il", il, eil);
            if (stb != 6'b0) strobe_seen++;
            nx = tb_reg;
            if (cl)  nx = '0;
            if (ld)  nx = data_out;
            if (inc) nx = tb_reg + 1'b1;
            if (dec) nx = tb_reg - 1'b1;
            if (sr)  nx = {ir, tb_reg[DW-1:1]};
            if (sl)  nx = {tb_reg[DW-2:0], il};
            reg_next = nx;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    cur = sb.pop_front();
                    check("err", err, cur.err);
                    check("latency", ncyc, cur.done_at);
                    check("strobe_count", strobe_seen, cur.n);
                    check("reg_value", tb_reg, cur.regv);
                    check("data_out", data_out, cur.data);
                end
                strobe_seen = 0;
            end else begin
                check("err_without_done", err, 0);
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge clk); #1;
        while (!cmd_ready && k < 64) begin
            @(negedge clk); #1;
            k++;
        end
        check("ready_timeout", cmd_ready, 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [CW-1:0] cnt, input logic fill,
                         input logic [DW-1:0] data, input bit noise);
        exp_t          e;
        logic [DW-1:0] r;
        logic          er;
        int            s, l, k;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_fill = fill; cmd_data = data;
        r = model_reg;
        model(op, int'(cnt), fill, data, r, er, s, l);
        model_reg = r;
        e.op = op; e.fill = fill; e.data = data; e.err = er; e.n = s; e.regv = r;
        e.done_at = ncyc + l;
        sb.push_back(e);
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!cmd_ready && k < 64) begin
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 3'($urandom); cmd_cnt = CW'($urandom);
                cmd_fill = 1'($urandom); cmd_data = DW'($urandom);
            end
            @(negedge clk); #1;
            cmd_valid = 1'b0;
            k++;
        end
        check("busy_timeout", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] c;
        exp_t          e;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {cl, ld, inc, dec, sr, sl, ir, il, busy, done, err}, 0);
        check("reset_data_out", data_out, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("ready_after_reset", cmd_ready, 1);

        issue(3'd1, 4'd3, 1'b0, 16'hA5A5, 1'b0);
        check("load_data_out", data_out, 16'hA5A5);
        check("load_reg", tb_reg, 16'hA5A5);

        issue(3'd0, 4'd9, 1'b0, 16'h1234, 1'b0);
        issue(3'd2, 4'd5, 1'b0, 16'h0000, 1'b1);
        check("inc5_reg", tb_reg, 16'h0005);

        issue(3'd1, 4'd0, 1'b0, 16'h000F, 1'b0);
        issue(3'd6, 4'd4, 1'b0, 16'h0000, 1'b0);
        check("ror4_reg", tb_reg, ROT ? 16'hF000 : 16'h000F);

        issue(3'd5, 4'd0, 1'b1, 16'h5555, 1'b1);
        issue(3'd4, 4'd15, 1'b1, 16'h0F0F, 1'b1);

        // Abort a long DEC after seven strobes.
        issue(3'd1, 4'd0, 1'b0, 16'h0100, 1'b0);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = 4'd15; cmd_fill = 1'b0; cmd_data = 16'hBEEF;
        e.op = 3'd3; e.fill = 1'b0; e.data = 16'hBEEF; e.err = 1'b0; e.n = 15;
        e.regv = model_reg - 16'd15; e.done_at = ncyc + 16;
        sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_reg = model_reg - 16'd7;
        check("abort_outputs", {cl, ld, inc, dec, sr, sl, ir, il, busy, done, err}, 0);
        check("abort_data_out", data_out, 0);
        check("abort_reg", tb_reg, model_reg);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("ready_after_abort", cmd_ready, 1);
        check("idle_after_abort", busy, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       c = '0;
                1:       c = '1;
                default: c = CW'($urandom_range(1, 14));
            endcase
            issue(3'($urandom), c, 1'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the load data path.
REQ-002 Parameter CNT_WIDTH, default 4, SHALL set the width of the repeat count.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode: 000 CLR, 001 LOAD, 010 INC, 011 DEC, 100 SHR, 101 SHL, 110 ROR, 111 ROL
- cmd_cnt  in  CNT_WIDTH  repeat count for INC/DEC/SHR/SHL/ROR/ROL
- cmd_fill  in  1  serial fill bit for SHR/SHL
- cmd_data  in  DATA_WIDTH  load value for LOAD
- reg_msb  in  1  downstream register bit DATA_WIDTH-1
- reg_lsb  in  1  downstream register bit 0
- cl, ld, inc, dec, sr, sl  out  1 each  register control strobes
- ir, il  out  1 each  register serial inputs
- data_out  out  DATA_WIDTH  value to drive the register load input
- busy  out  1  a command is in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for a rejected opcode

Function
REQ-005 The block SHALL implement three states: IDLE, RUN and FIN.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-007 On accept, the block SHALL capture cmd_op, cmd_cnt, cmd_fill and cmd_data; data_out SHALL hold the captured cmd_data until the next accept.
REQ-008 For CLR and LOAD, the block SHALL ignore cmd_cnt and assert exactly one strobe (cl or ld, respectively) in the cycle after accept.
REQ-009 For INC, DEC, SHR, SHL, ROR and ROL with captured count N>0, the block SHALL assert its strobe for exactly N consecutive cycles, starting the cycle after accept.
- INC and DEC assert inc and dec.
- SHR and ROR assert sr.
- SHL and ROL assert sl.
REQ-010 With N=0, the block SHALL assert no strobe and SHALL go from accept directly to FIN.
REQ-011 At most one of cl, ld, inc, dec, sr and sl SHALL be 1 in any cycle; all strobes SHALL be driven from flops.
REQ-012 During SHR, ir SHALL equal the captured fill bit; during SHL, il SHALL equal the captured fill bit.
REQ-013 During ROR, ir SHALL equal reg_lsb combinationally; during ROL, il SHALL equal reg_msb combinationally.
REQ-014 When no shift or rotate is in progress, ir and il SHALL be 0.
REQ-015 An internal remaining-count counter SHALL decrement once per strobe cycle; the state SHALL enter FIN on the edge that ends the last strobe cycle.
REQ-016 FIN SHALL last exactly one cycle, with done=1 and cmd_ready=0; the next state SHALL be IDLE.
REQ-017 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-018 Total latency SHALL be N+1 cycles from the accept edge to the done cycle; for CLR and LOAD it SHALL be 2 cycles.
REQ-019 With cmd_cnt at its maximum value (2^CNT_WIDTH-1), the counter SHALL NOT wrap, and the block SHALL issue exactly 2^CNT_WIDTH-1 strobes.
REQ-020 A cmd_valid asserted while busy=1 SHALL be ignored; the command SHALL NOT be captured or queued.

Reset
REQ-021 Asserting rst_n=0 at any time, including mid-sequence, SHALL immediately force the state to IDLE and force all strobes, ir, il, busy, done, err and data_out to 0.
REQ-022 The remaining-count counter SHALL be forced to 0 on reset.
REQ-023 cmd_ready SHALL be 1 while in reset-exit IDLE, starting with the first cycle after rst_n rises.
REQ-024 An aborted sequence SHALL NOT produce a done pulse.

Configuration
REQ-025 Macro REG_SEQ_ROTATE_EN SHALL control rotate support.
- Defined: ROR and ROL SHALL execute per REQ-009 and REQ-013.
- Undefined: the reg_msb/reg_lsb feedback logic SHALL be absent; a ROR or ROL accept SHALL assert no strobe and SHALL go to FIN with done=1 and err=1.
REQ-026 err SHALL be 0 for all other opcodes in either build.

Verification
REQ-027 A bench SHALL cover the following directed scenarios:
- LOAD with cmd_data=16'hA5A5 -> ld=1 for one cycle at accept+1; done at accept+2; data_out=16'hA5A5.
- INC with cmd_cnt=5, register starting at 0 -> inc=1 for 5 cycles; register=5; done at accept+6.
- ROR ×4 on register 16'h000F with REG_SEQ_ROTATE_EN defined -> register=16'hF000; with the macro undefined -> no strobe, done=1 and err=1 at accept+1.
- SHL with cmd_cnt=0 -> no strobe; done at accept+1; a cmd_valid asserted during busy is ignored.
- DEC with cmd_cnt=15, rst_n pulsed low after 7 strobes -> all outputs 0 immediately; no done pulse; cmd_ready=1 the first cycle after reset release.
